uart_tx_arb: RTL and testbench
==============================

UART_TX_ARB -- requirements
Module: uart_tx_arb

Interface
REQ-001 SHALL have parameter NUM_REQ, 4, number of byte-stream requesters (2..8).
REQ-002 SHALL have parameter REQ_W, 2, width of grant_id; equals ceil(log2(NUM_REQ)).
REQ-003 SHALL have parameter TIMEOUT, 255, idle cycles allowed mid-packet before a grant is revoked (1..255).
REQ-004 SHALL have port clk  in  1  single clock for all logic.
REQ-005 SHALL have port resetb  in  1  reset, asynchronous, active-low.
REQ-006 SHALL have port req_valid  in  NUM_REQ  per-requester byte valid.
REQ-007 SHALL have port req_last  in  NUM_REQ  per-requester last-byte-of-packet flag, qualified by req_valid.
REQ-008 SHALL have port req_data  in  8*NUM_REQ  per-requester byte; requester i occupies bits [8i+7:8i].
REQ-009 SHALL have port req_ready  out  NUM_REQ  per-requester byte accept, one-hot or zero.
REQ-010 SHALL have port we  out  1  one-cycle write strobe to the UART transmitter.
REQ-011 SHALL have port tx_data  out  8  byte to the UART transmitter.
REQ-012 SHALL have port tx_busy  in  1  UART transmitter busy.
REQ-013 SHALL have port tx_done  in  1  UART transmitter one-cycle byte-complete pulse.
REQ-014 SHALL have port grant_valid  out  1  a requester currently owns the transmitter.
REQ-015 SHALL have port grant_id  out  REQ_W  index of the owning requester; meaningful only when grant_valid=1.

Function
REQ-016 SHALL implement states IDLE, GRANT, SEND and WAIT.
REQ-017 IDLE: when any req_valid=1 and tx_busy=0, SHALL select the first requester at or above rr_ptr, wrapping modulo NUM_REQ, and move to GRANT next cycle with grant_valid=1 and grant_id set.
REQ-018 GRANT: req_ready[grant_id] SHALL be 1 only when req_valid[grant_id]=1 and tx_busy=0; all other req_ready bits SHALL be 0.
REQ-019 A byte is accepted on a cycle with req_valid & req_ready; on acceptance, tx_data and the captured last flag SHALL be registered and the state SHALL become SEND.
REQ-020 SEND: we SHALL be 1 for exactly one cycle (one cycle after acceptance); the state SHALL become WAIT.
REQ-021 WAIT: on tx_done=1, if the captured last flag=1 the block SHALL return to IDLE, set rr_ptr=(grant_id+1) mod NUM_REQ and clear grant_valid; otherwise it SHALL return to GRANT.
REQ-022 tx_done SHALL be ignored in IDLE, GRANT and SEND.
REQ-023 In GRANT, an 8-bit idle counter SHALL increment on each cycle with req_valid[grant_id]=0; reaching TIMEOUT SHALL force IDLE with rr_ptr advanced as in REQ-021. The counter SHALL clear on acceptance and on entry to GRANT.
REQ-024 tx_data SHALL hold its value outside SEND; we SHALL never be asserted while tx_busy=1.
REQ-025 At most one byte SHALL be outstanding; throughput is one byte per UART frame.
REQ-026 Requests from non-granted requesters SHALL have no effect until the current packet ends or times out.

Reset
REQ-027 With resetb=0, the block SHALL asynchronously force state=IDLE, rr_ptr=0, idle counter=0, req_ready=0, we=0, tx_data=8'h00, grant_valid=0 and grant_id=0.
REQ-028 Reset asserted mid-packet SHALL abandon the packet; no we pulse SHALL follow reset release unless a new acceptance occurs.

Structure
REQ-029 State encoding localparams and the TIMEOUT counter width SHALL reside in shared package uart_pkg.
REQ-030 The round-robin selection SHALL be a separate combinational sub-module uart_rr_pick (inputs: request vector, rr_ptr; outputs: found, index).

Verification
REQ-031 Single requester 0 sends a 3-byte packet (0x11, 0x22, 0x33 with last) -> three we pulses with those bytes, one per tx_done; grant_valid drops after the third tx_done; rr_ptr=1.
REQ-032 Requesters 0 and 2 both valid from reset -> packet from 0 completes fully, then requester 2 is granted; there is no interleaving of bytes.
REQ-033 All four requesters continuously send 1-byte packets -> grant order 0,1,2,3,0.
REQ-034 Requester 1 granted, then drops valid for 255 cycles mid-packet -> grant is released, rr_ptr=2, and waiting requester 3 is granted.
REQ-035 tx_busy held at 1 while req_valid[0]=1 -> no grant and no we; after tx_busy falls, grant occurs on the next cycle.
REQ-036 resetb pulsed low during WAIT -> all outputs return to reset values immediately; no we pulse occurs until the next acceptance.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared types for the UART transmit arbiter: FSM encoding and
// the width of the mid-packet idle counter.
package uart_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_GRANT = 2'd1;
    localparam logic [1:0] ST_SEND  = 2'd2;
    localparam logic [1:0] ST_WAIT  = 2'd3;

    typedef enum logic [1:0] {
        IDLE  = ST_IDLE,
        GRANT = ST_GRANT,
        SEND  = ST_SEND,
        WAIT  = ST_WAIT
    } state_e;

    localparam int CNT_W = 8;
    typedef logic [CNT_W-1:0] cnt_t;

endpackage

// File: rtl/uart_rr_pick.sv
// Round-robin picker: first set request at or above ptr, wrapping
// modulo N.
module uart_rr_pick #(
    parameter int N = 4,
    parameter int W = 2
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] ptr,
    output logic         found,
    output logic [W-1:0] index
);

    logic [W-1:0] j;

    // Walk offsets high to low so the smallest offset wins.
    always_comb begin
        found = 1'b0;
        index = '0;
        j     = '0;
        for (int i = N - 1; i >= 0; i--) begin
            j = W'((int'(ptr) + i) % N);
            if (req[j]) begin
                found = 1'b1;
                index = j;
            end
        end
    end

endmodule

// File: rtl/uart_tx_arb.sv
// Packet-granular round-robin arbiter feeding one byte at a time
// to a UART transmitter, with a mid-packet idle timeout.
module uart_tx_arb
    import uart_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int REQ_W   = 2,
    parameter int TIMEOUT = 255
) (
    input  logic                 clk,
    input  logic                 resetb,
    input  logic [NUM_REQ-1:0]   req_valid,
    input  logic [NUM_REQ-1:0]   req_last,
    input  logic [8*NUM_REQ-1:0] req_data,
    output logic [NUM_REQ-1:0]   req_ready,
    output logic                 we,
    output logic [7:0]           tx_data,
    input  logic                 tx_busy,
    input  logic                 tx_done,
    output logic                 grant_valid,
    output logic [REQ_W-1:0]     grant_id
);

    state_e           state_q, state_d;
    logic [REQ_W-1:0] rr_ptr_q, rr_ptr_d;
    logic [REQ_W-1:0] gid_q, gid_d;
    logic             gv_q, gv_d;
    logic             last_q, last_d;
    logic [7:0]       tx_data_q, tx_data_d;
    cnt_t             cnt_q, cnt_d;

    logic             pick_found;
    logic [REQ_W-1:0] pick_idx;
    logic [REQ_W-1:0] ptr_after;

    uart_rr_pick #(
        .N (NUM_REQ),
        .W (REQ_W)
    ) u_pick (
        .req   (req_valid),
        .ptr   (rr_ptr_q),
        .found (pick_found),
        .index (pick_idx)
    );

    assign ptr_after = (gid_q == REQ_W'(NUM_REQ - 1)) ? '0 : gid_q + 1'b1;

    always_comb begin
        state_d   = state_q;
        rr_ptr_d  = rr_ptr_q;
        gid_d     = gid_q;
        gv_d      = gv_q;
        last_d    = last_q;
        tx_data_d = tx_data_q;
        cnt_d     = cnt_q;
        req_ready = '0;
        we        = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (pick_found && !tx_busy) begin
                    state_d = GRANT;
                    gv_d    = 1'b1;
                    gid_d   = pick_idx;
                    cnt_d   = '0;
                end
            end
            GRANT: begin
                if (req_valid[gid_q] && !tx_busy) begin
                    req_ready[gid_q] = 1'b1;
                    tx_data_d = req_data[{gid_q, 3'b000} +: 8];
                    last_d    = req_last[gid_q];
                    cnt_d     = '0;
                    state_d   = SEND;
                end else if (!req_valid[gid_q]) begin
                    // Owner stalled mid-packet: release after TIMEOUT idle cycles.
                    if (cnt_q == cnt_t'(TIMEOUT - 1)) begin
                        state_d  = IDLE;
                        gv_d     = 1'b0;
                        rr_ptr_d = ptr_after;
                        cnt_d    = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            SEND: begin
                we      = 1'b1;
                state_d = WAIT;
            end
            WAIT: begin
                if (tx_done) begin
                    if (last_q) begin
                        state_d  = IDLE;
                        gv_d     = 1'b0;
                        rr_ptr_d = ptr_after;
                    end else begin
                        state_d = GRANT;
                        cnt_d   = '0;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            state_q   <= IDLE;
            rr_ptr_q  <= '0;
            gid_q     <= '0;
            gv_q      <= 1'b0;
            last_q    <= 1'b0;
            tx_data_q <= 8'h00;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            rr_ptr_q  <= rr_ptr_d;
            gid_q     <= gid_d;
            gv_q      <= gv_d;
            last_q    <= last_d;
            tx_data_q <= tx_data_d;
            cnt_q     <= cnt_d;
        end
    end

    assign tx_data     = tx_data_q;
    assign grant_valid = gv_q;
    assign grant_id    = gid_q;

endmodule

// File: tb/tb_uart_tx_arb.sv
// Directed and randomized bench for uart_tx_arb against a
// packet-level round-robin reference model and a UART model.
module tb_uart_tx_arb;

    localparam int N  = 4;
    localparam int W  = 2;
    localparam int TO = 255;

    logic           clk = 1'b0;
    logic           resetb;
    logic [N-1:0]   req_valid, req_last, req_ready;
    logic [8*N-1:0] req_data;
    logic           we, tx_busy, tx_done, grant_valid;
    logic [7:0]     tx_data;
    logic [W-1:0]   grant_id;

    always #5 clk = ~clk;

    uart_tx_arb #(.NUM_REQ(N), .REQ_W(W), .TIMEOUT(TO)) dut (
        .clk         (clk),
        .resetb      (resetb),
        .req_valid   (req_valid),
        .req_last    (req_last),
        .req_data    (req_data),
        .req_ready   (req_ready),
        .we          (we),
        .tx_data     (tx_data),
        .tx_busy     (tx_busy),
        .tx_done     (tx_done),
        .grant_valid (grant_valid),
        .grant_id    (grant_id)
    );

    int         n_chk = 0;
    int         n_pass = 0;
    logic [8:0] rq[N][$];
    int         gap[N];
    int         force_gap[N];
    bit         gap_en, uart_auto, ubusy;
    int         ucnt;
    logic [7:0] exp_bytes[$];
    int         exp_grant[$];
    logic [N-1:0] acc;
    bit         we_s, done_s, gv_prev;
    int         we_total, done_total;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic push_byte(input int r, input logic [7:0] d, input bit last);
        rq[r].push_back({last, d});
    endtask

    task automatic drive_reqs();
        logic [8:0] e;
        for (int i = 0; i < N; i++) begin
            if (gap[i] > 0) begin
                gap[i]--;
                req_valid[i] = 1'b0;
            end else if (rq[i].size() > 0) begin
                e = rq[i][0];
                req_valid[i] = 1'b1;
                req_last[i]  = e[8];
                req_data[8*i +: 8] = e[7:0];
            end else begin
                req_valid[i] = 1'b0;
            end
        end
    endtask

    // One clock: update UART and requesters after the edge, sample at negedge.
    task automatic step();
        logic [8:0] e;
        @(posedge clk);
        #1;
        if (uart_auto) begin
            tx_done = 1'b0;
            if (ubusy) begin
                ucnt--;
                if (ucnt == 0) begin
                    ubusy   = 1'b0;
                    tx_done = 1'b1;
                end
            end
            if (we_s) begin
                ubusy = 1'b1;
                ucnt  = $urandom_range(2, 6);
            end
            tx_busy = ubusy;
        end
        for (int i = 0; i < N; i++) begin
            if (acc[i]) begin
                e = rq[i].pop_front();
                if (!e[8]) begin
                    if (force_gap[i] > 0) begin
                        gap[i] = force_gap[i];
                        force_gap[i] = 0;
                    end else if (gap_en) begin
                        gap[i] = $urandom_range(0, 3);
                    end
                end
            end
        end
        drive_reqs();
        @(negedge clk);
        acc    = req_valid & req_ready;
        we_s   = we;
        done_s = tx_done;
        chk("ready_onehot0", 32'($onehot0(req_ready)), 1);
        if (we) begin
            we_total++;
            chk("we_while_busy", tx_busy, 0);
            if (exp_bytes.size() > 0) chk("tx_data", tx_data, exp_bytes.pop_front());
            else chk("spurious_we", we, 0);
        end
        if (tx_done) done_total++;
        if (grant_valid && !gv_prev) begin
            if (exp_grant.size() > 0) chk("grant_id", grant_id, exp_grant.pop_front());
            else chk("spurious_grant", grant_valid, 0);
        end
        gv_prev = grant_valid;
    endtask

    task automatic do_reset();
        resetb = 1'b0;
        for (int i = 0; i < N; i++) begin
            rq[i].delete();
            gap[i] = 0;
            force_gap[i] = 0;
        end
        exp_bytes.delete();
        exp_grant.delete();
        req_valid = '0;
        req_last  = '0;
        req_data  = '0;
        tx_busy = 1'b0;
        tx_done = 1'b0;
        ubusy = 1'b0;
        ucnt  = 0;
        acc   = '0;
        we_s  = 1'b0;
        done_s = 1'b0;
        gv_prev = 1'b0;
        we_total = 0;
        done_total = 0;
        uart_auto = 1'b1;
        gap_en = 1'b0;
        repeat (2) @(negedge clk);
        resetb = 1'b1;
    endtask

    // Packet-level reference: whole packets granted round-robin.
    function automatic void model(input int start_ptr);
        logic [8:0] m[N][$];
        logic [8:0] e;
        int ptr, j;
        bit any;
        ptr = start_ptr;
        for (int i = 0; i < N; i++) m[i] = rq[i];
        while (1) begin
            any = 1'b0;
            for (int k = 0; k < N && !any; k++) begin
                j = (ptr + k) % N;
                if (m[j].size() > 0) begin
                    any = 1'b1;
                    exp_grant.push_back(j);
                    do begin
                        e = m[j].pop_front();
                        exp_bytes.push_back(e[7:0]);
                    end while (!e[8]);
                    ptr = (j + 1) % N;
                end
            end
            if (!any) break;
        end
    endfunction

    task automatic drain(input string tag, input int budget);
        int n = 0;
        while ((exp_bytes.size() > 0 || exp_grant.size() > 0 || grant_valid) && n < budget) begin
            step();
            n++;
        end
        chk({tag, "_in_budget"}, 32'(n < budget), 1);
        chk({tag, "_bytes_left"}, exp_bytes.size(), 0);
        chk({tag, "_grants_left"}, exp_grant.size(), 0);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_req_ready"}, req_ready, 0);
        chk({tag, "_we"}, we, 0);
        chk({tag, "_tx_data"}, tx_data, 0);
        chk({tag, "_grant_valid"}, grant_valid, 0);
        chk({tag, "_grant_id"}, grant_id, 0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, k, npk, len;
        resetb = 1'b1;
        req_valid = '0;
        req_last  = '0;
        req_data  = '0;
        tx_busy = 1'b0;
        tx_done = 1'b0;
        #1 resetb = 1'b0;
        #1 check_reset_outputs("por");
        do_reset();

        // Single requester, 3-byte packet, then rr_ptr must be 1
        push_byte(0, 8'h11, 0);
        push_byte(0, 8'h22, 0);
        push_byte(0, 8'h33, 1);
        model(0);
        n = 0;
        while (done_total < 3 && n < 500) begin
            step();
            n++;
        end
        chk("single_three_done", done_total, 3);
        chk("single_gv_before_last_done", grant_valid, 1);
        step();
        chk("single_gv_after_last_done", grant_valid, 0);
        chk("single_we_count", we_total, 3);
        push_byte(0, 8'h44, 1);
        push_byte(1, 8'h55, 1);
        model(1);
        drain("ptr_after_pkt", 500);

        // Requesters 0 and 2 valid from reset, no interleaving
        do_reset();
        gap_en = 1'b1;
        push_byte(0, 8'hA0, 0);
        push_byte(0, 8'hA1, 0);
        push_byte(0, 8'hA2, 1);
        push_byte(2, 8'hB0, 0);
        push_byte(2, 8'hB1, 1);
        model(0);
        drain("two_req", 1000);

        // All four continuously sending 1-byte packets
        do_reset();
        for (int r = 0; r < N; r++) begin
            push_byte(r, 8'(8'h10 * r + 1), 1);
            push_byte(r, 8'(8'h10 * r + 2), 1);
        end
        model(0);
        drain("four_req", 1000);

        // Requester 1 stalls mid-packet, requester 3 waiting
        do_reset();
        push_byte(1, 8'hD1, 0);
        push_byte(1, 8'hD2, 1);
        push_byte(3, 8'hC3, 1);
        force_gap[1] = 300;
        exp_bytes = '{8'hD1, 8'hC3, 8'hD2};
        exp_grant = '{1, 3, 1};
        n = 0;
        while (done_total < 1 && n < 500) begin
            step();
            n++;
        end
        chk("timeout_first_done", done_total, 1);
        k = 0;
        step();
        while (grant_valid && k < TO + 10) begin
            k++;
            step();
        end
        chk("timeout_cycles", k, TO);
        drain("timeout", 1000);

        // tx_busy held high blocks the grant
        do_reset();
        uart_auto = 1'b0;
        tx_busy = 1'b1;
        push_byte(0, 8'h5A, 1);
        exp_bytes = '{8'h5A};
        exp_grant = '{0};
        repeat (10) step();
        chk("busy_no_grant", grant_valid, 0);
        chk("busy_no_we", we_total, 0);
        tx_busy = 1'b0;
        uart_auto = 1'b1;
        step();
        chk("busy_grant_next_cycle", grant_valid, 1);
        drain("busy", 500);

        // Reset pulsed during WAIT
        do_reset();
        push_byte(2, 8'h61, 0);
        push_byte(2, 8'h62, 1);
        exp_bytes = '{8'h61, 8'h62};
        exp_grant = '{2};
        n = 0;
        while (we_total < 1 && n < 200) begin
            step();
            n++;
        end
        step();
        chk("wait_gv_before_reset", grant_valid, 1);
        chk("wait_gid_before_reset", grant_id, 2);
        #1 resetb = 1'b0;
        #1 check_reset_outputs("mid_reset");
        do_reset();
        repeat (30) step();
        chk("no_we_after_reset", we_total, 0);
        push_byte(1, 8'h77, 1);
        model(0);
        drain("after_reset", 500);

        // Randomized packet mixes
        for (int round = 0; round < 4; round++) begin
            do_reset();
            gap_en = 1'b1;
            for (int r = 0; r < N; r++) begin
                npk = $urandom_range(0, 3);
                for (int p = 0; p < npk; p++) begin
                    len = $urandom_range(1, 4);
                    for (int b = 0; b < len; b++)
                        push_byte(r, 8'($urandom), b == len - 1);
                end
            end
            model(0);
            drain("random", 4000);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
